// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response port of the IF stage.
// Single outstanding request: req/ready accept, rvalid/rdata return.
interface if_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, addr,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  req, addr,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, fetches one word at a time, feeds the F/D register.
// Optional FETCH_BYPASS_EN forwards imem_rdata straight to decode.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  if_fetch_unit_if.master   imem,
  input  logic              stall_D,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              fd_en,
  output logic              fd_valid,
  output logic [31:0]       N_Instr_D,
  output logic [31:0]       N_PC4_D,
  output logic [31:0]       N_PC8_D
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        drop_q, drop_d;
`ifdef FETCH_BYPASS_EN
  logic        bypass;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    drop_d  = drop_q;
`ifdef FETCH_BYPASS_EN
    bypass  = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem.ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem.rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else
`ifdef FETCH_BYPASS_EN
          if (!stall_D && !redirect) begin
            bypass  = 1'b1;
            pc_d    = pc_q + 32'd4;
            state_d = S_REQ;
          end else
`endif
          begin
            instr_d = imem.rdata;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stall_D) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A redirect wins over stall and advance; an in-flight old fetch is dropped
    if (redirect) begin
      pc_d = redirect_pc & ~32'd3;
      unique case (state_q)
        S_REQ: begin
          if (imem.ready) begin
            state_d = S_WAIT;
            drop_d  = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end
        S_WAIT: begin
          if (imem.rvalid) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  assign imem.req  = (state_q == S_REQ);
  assign imem.addr = pc_q;

  assign fd_en   = ~stall_D;
  assign N_PC4_D = pc_q + 32'd4;
  assign N_PC8_D = pc_q + 32'd8;

`ifdef FETCH_BYPASS_EN
  assign fd_valid  = (state_q == S_HOLD) | bypass;
  assign N_Instr_D = bypass ? imem.rdata :
                     (state_q == S_HOLD) ? instr_q : NOP_INSTR;
`else
  assign fd_valid  = (state_q == S_HOLD);
  assign N_Instr_D = fd_valid ? instr_q : NOP_INSTR;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a transaction-level fetch model.
// Memory returns addr ^ 32'hA5A5_5A5A after a programmable latency.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_D;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fd_en;
  logic        fd_valid;
  logic [31:0] N_Instr_D;
  logic [31:0] N_PC4_D;
  logic [31:0] N_PC8_D;

  if_fetch_unit_if imem ();

  if_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (imem),
    .stall_D     (stall_D),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fd_en       (fd_en),
    .fd_valid    (fd_valid),
    .N_Instr_D   (N_Instr_D),
    .N_PC4_D     (N_PC4_D),
    .N_PC8_D     (N_PC8_D)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mw(logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // Fetch model in transaction terms: pending fetch, stale flag, held word
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
    logic        out;
    logic        stale;
    logic        have;
    logic        started;
  } m_t;

  m_t m;

  function automatic logic m_req(m_t s);
    return s.started & ~s.out & ~s.have;
  endfunction

  function automatic logic m_byp(m_t s, logic rv, logic st, logic rdr);
`ifdef FETCH_BYPASS_EN
    return s.out & rv & ~s.stale & ~st & ~rdr;
`else
    return 1'b0 & s.out & rv & st & rdr;
`endif
  endfunction

  function automatic m_t step(m_t s, logic rdy, logic rv, logic [31:0] rd,
                              logic st, logic rdr, logic [31:0] tgt);
    m_t  n = s;
    logic acc = m_req(s) & rdy;
    logic resp = s.out & rv;
    if (rdr) begin
      if (acc) begin
        n.out = 1'b1;
        n.stale = 1'b1;
      end else if (resp) begin
        n.out = 1'b0;
        n.stale = 1'b0;
      end else if (s.out) begin
        n.stale = 1'b1;
      end
      n.have = 1'b0;
      n.pc = tgt & ~32'd3;
      n.started = 1'b1;
    end else if (!s.started) begin
      n.started = 1'b1;
    end else if (acc) begin
      n.out = 1'b1;
    end else if (resp) begin
      n.out = 1'b0;
      if (s.stale) n.stale = 1'b0;
      else if (m_byp(s, rv, st, rdr)) n.pc = s.pc + 32'd4;
      else begin
        n.have = 1'b1;
        n.word = rd;
      end
    end else if (s.have && !st) begin
      n.have = 1'b0;
      n.pc = s.pc + 32'd4;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      m <= '{pc: 32'h3000, word: 32'h0, out: 1'b0,
             stale: 1'b0, have: 1'b0, started: 1'b0};
    else
      m <= step(m, imem.ready, imem.rvalid, imem.rdata,
                stall_D, redirect, redirect_pc);
  end

  always @(negedge clk) begin
    logic        er;
    logic        eb;
    logic        efv;
    logic [31:0] ei;
    er  = m_req(m);
    eb  = m_byp(m, imem.rvalid, stall_D, redirect);
    efv = m.have | eb;
    ei  = eb ? imem.rdata : (m.have ? m.word : 32'h0);
    chk("imem_req", {31'b0, imem.req}, {31'b0, er});
    if (er) chk("imem_addr", imem.addr, m.pc);
    chk("fd_en", {31'b0, fd_en}, {31'b0, ~stall_D});
    chk("fd_valid", {31'b0, fd_valid}, {31'b0, efv});
    chk("N_Instr_D", N_Instr_D, ei);
    chk("N_PC4_D", N_PC4_D, m.pc + 32'd4);
    chk("N_PC8_D", N_PC8_D, m.pc + 32'd8);
  end

  // Stimulus, memory responder and activity logs
  int          lat = 1;
  int          cnt = -1;
  int          cyc = 0;
  logic        acc;
  logic [31:0] acc_a;
  logic [31:0] paddr;
  logic [31:0] acc_q[$];
  int          accc_q[$];
  logic [31:0] dl_q[$];
  logic [31:0] pc4_q[$];

  task automatic tick();
    @(negedge clk);
    acc   = imem.req & imem.ready & rst_n;
    acc_a = imem.addr;
    if (acc) begin
      acc_q.push_back(acc_a);
      accc_q.push_back(cyc);
    end
    if (fd_valid & fd_en) begin
      dl_q.push_back(N_Instr_D);
      pc4_q.push_back(N_PC4_D);
    end
    @(posedge clk);
    cyc++;
    #2;
    redirect    = 1'b0;
    imem.rvalid = 1'b0;
    imem.rdata  = 32'hDEAD_BEEF;
    if (acc) begin
      cnt   = lat - 1;
      paddr = acc_a;
    end else if (cnt >= 0) begin
      cnt--;
    end
    if (cnt == 0) begin
      imem.rvalid = 1'b1;
      imem.rdata  = mw(paddr);
    end
  endtask

  task automatic timeout(string nm);
    checks++;
    errors++;
    $display("FAIL %s: got timeout want event", nm);
  endtask

  task automatic wait_acc(string nm);
    for (int k = 0; k < 40; k++) begin
      tick();
      if (acc) return;
    end
    timeout(nm);
  endtask

  task automatic wait_fv(string nm);
    for (int k = 0; k < 40; k++) begin
      if (fd_valid) return;
      tick();
    end
    timeout(nm);
  endtask

  task automatic wait_req(string nm);
    for (int k = 0; k < 40; k++) begin
      if (imem.req) return;
      tick();
    end
    timeout(nm);
  endtask

  initial begin
    logic [31:0] stale;
    logic [31:0] nxt;
    int          a0;
    int          d0;
    logic        bad;

    rst_n       = 1'b0;
    stall_D     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem.ready  = 1'b1;
    imem.rvalid = 1'b0;
    imem.rdata  = 32'hDEAD_BEEF;

    @(posedge clk);
    #2;
    chk("rst_req", {31'b0, imem.req}, 32'h0);
    chk("rst_fd_valid", {31'b0, fd_valid}, 32'h0);
    chk("rst_instr", N_Instr_D, 32'h0);
    chk("rst_pc4", N_PC4_D, 32'h3004);
    chk("rst_pc8", N_PC8_D, 32'h3008);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // 1: back-to-back fetch, 1-cycle latency
    for (int k = 0; k < 40 && acc_q.size() < 3; k++) tick();
    if (acc_q.size() < 3) timeout("t1_fetch");
    else begin
      chk("t1_addr0", acc_q[0], 32'h3000);
      chk("t1_addr1", acc_q[1], 32'h3004);
      chk("t1_addr2", acc_q[2], 32'h3008);
`ifdef FETCH_BYPASS_EN
      chk("t1_issue_gap", accc_q[1] - accc_q[0], 32'd2);
`else
      chk("t1_issue_gap", accc_q[1] - accc_q[0], 32'd3);
`endif
    end
    if (dl_q.size() < 1) timeout("t1_deliver");
    else begin
      chk("t1_instr0", dl_q[0], 32'hA5A5_6A5A);
      chk("t1_pc4_0", pc4_q[0], 32'h3004);
    end

    // 2: stall while holding
    stall_D = 1'b1;
    wait_fv("t2_hold");
    a0 = acc_q.size();
    repeat (3) tick();
    chk("t2_no_req", acc_q.size(), a0);
    chk("t2_pc4", N_PC4_D, acc_q[$] + 32'd4);
    chk("t2_instr", N_Instr_D, mw(acc_q[$]));
    nxt = acc_q[$] + 32'd4;
    stall_D = 1'b0;
    wait_acc("t2_adv");
    chk("t2_next", acc_q[$], nxt);

    // 3: redirect in WAIT, stale response two cycles later
    lat = 3;
    wait_acc("t3_acc");
    stale = acc_q[$];
    d0 = dl_q.size();
    redirect = 1'b1;
    redirect_pc = 32'h3402;
    tick();
    wait_acc("t3_reacc");
    chk("t3_target", acc_q[$], 32'h3400);
    repeat (6) tick();
    bad = 1'b0;
    for (int i = d0; i < dl_q.size(); i++)
      if (dl_q[i] == mw(stale)) bad = 1'b1;
    chk("t3_stale_hidden", {31'b0, bad}, 32'h0);

    // 4: redirect on the accepting cycle of REQ
    lat = 1;
    wait_req("t4_req");
    stale = imem.addr;
    d0 = dl_q.size();
    redirect = 1'b1;
    redirect_pc = 32'h3800;
    tick();
    wait_acc("t4_reacc");
    chk("t4_target", acc_q[$], 32'h3800);
    wait_fv("t4_fv");
    chk("t4_instr", N_Instr_D, 32'hA5A5_625A);
    bad = 1'b0;
    for (int i = d0; i < dl_q.size(); i++)
      if (dl_q[i] == mw(stale)) bad = 1'b1;
    chk("t4_stale_hidden", {31'b0, bad}, 32'h0);

    // 5a: redirect coinciding with rvalid
    lat = 2;
    wait_acc("t5_acc");
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h3C00;
    tick();
    wait_acc("t5_reacc");
    chk("t5_target", acc_q[$], 32'h3C00);
    wait_fv("t5_fv");
    chk("t5_instr", N_Instr_D, mw(32'h3C00));

    // 5b: redirect while decode is stalled
    stall_D = 1'b1;
    tick();
    chk("t5_fd_en", {31'b0, fd_en}, 32'h0);
    redirect = 1'b1;
    redirect_pc = 32'h4000;
    tick();
    chk("t5_discard", {31'b0, fd_valid}, 32'h0);
    wait_acc("t5_stall_acc");
    chk("t5_stall_target", acc_q[$], 32'h4000);
    stall_D = 1'b0;
    repeat (4) tick();

    // 6: wrap-around target, then async reset mid-WAIT
    lat = 3;
    wait_req("t6_req");
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    chk("t6_pc4", N_PC4_D, 32'h0000_0000);
    chk("t6_pc8", N_PC8_D, 32'h0000_0004);
    wait_acc("t6_acc");
    chk("t6_addr", acc_q[$], 32'hFFFF_FFFC);
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req", {31'b0, imem.req}, 32'h0);
    chk("t6_rst_fv", {31'b0, fd_valid}, 32'h0);
    chk("t6_rst_instr", N_Instr_D, 32'h0);
    chk("t6_rst_pc4", N_PC4_D, 32'h3004);
    chk("t6_rst_pc8", N_PC8_D, 32'h3008);
    imem.ready = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("t6_req_after", {31'b0, imem.req}, 32'h1);
    chk("t6_addr_after", imem.addr, 32'h3000);
    imem.ready = 1'b1;
    wait_acc("t6_reacc");
    chk("t6_refetch", acc_q[$], 32'h3000);
    wait_fv("t6_fv");
    chk("t6_instr", N_Instr_D, 32'hA5A5_6A5A);
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
